// File: rtl/arb4_rr_pkg.sv
// Shared constants, state encoding and rotate-priority winner search for arb4_rr.
// rr_pick scans last+1, last+2, last+3, last (mod 4) and reports the first requester found.
package arb4_rr_pkg;

   localparam int NUM_REQ      = 4;
   localparam int MAX_HOLD_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

   function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req_v,
                                     input logic [1:0]         last);
      pick_t      p;
      logic [1:0] cand;
      p.found = 1'b0;
      p.idx   = 2'd0;
      // Walk from the lowest priority up so the highest-priority hit is written last.
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = last + 2'(k);
         if (req_v[cand]) begin
            p.found = 1'b1;
            p.idx   = cand;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/arb4_rr_grant_dec.sv
// 2-to-4 grant decoder with enable: one-hot output of idx_i, all zero when en_i is low.
// Purely combinational.
module arb4_rr_grant_dec
   import arb4_rr_pkg::*;
(
   input  logic [1:0]         idx_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o
);

   always_comb begin
      gnt_o = '0;
      if (en_i) gnt_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/arb4_rr.sv
// 4-way round-robin arbiter with hold-limit preemption; registered grant one cycle after request.
// An owner keeps the grant while requesting, until MAX_HOLD cycles elapse with another requester waiting.
module arb4_rr
   import arb4_rr_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [1:0]         gnt_idx,
   output logic               gnt_vld,
   output logic               preempt
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_e             state_q, state_d;
   logic [1:0]         idx_q, idx_d;
   logic [1:0]         last_q, last_d;
   logic [7:0]         hold_q, hold_d;
   logic               preempt_q, preempt_d;
   logic [NUM_REQ-1:0] others;
   pick_t              pick_all, pick_oth;

   always_comb begin
      others         = req;
      others[idx_q]  = 1'b0;
   end

   assign pick_all = rr_pick(req, last_q);
   assign pick_oth = rr_pick(others, last_q);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      hold_d    = hold_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_all.found) begin
               state_d = OWN;
               idx_d   = pick_all.idx;
               last_d  = pick_all.idx;
               hold_d  = 8'd0;
            end
         end
         OWN: begin
            // Release takes precedence over expiry, so a simultaneous drop never flags preempt.
            if (!req[idx_q]) begin
               if (pick_oth.found) begin
                  idx_d  = pick_oth.idx;
                  last_d = pick_oth.idx;
                  hold_d = 8'd0;
               end else begin
                  state_d = IDLE;
               end
            end else if (hold_q == HOLD_LAST && pick_oth.found) begin
               idx_d     = pick_oth.idx;
               last_d    = pick_oth.idx;
               hold_d    = 8'd0;
               preempt_d = 1'b1;
            end else if (hold_q != HOLD_LAST) begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= 2'd0;
         last_q    <= 2'd3;
         hold_q    <= 8'd0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   arb4_rr_grant_dec u_grant_dec (
      .idx_i (idx_q),
      .en_i  (state_q == OWN),
      .gnt_o (gnt)
   );

   assign gnt_idx = idx_q;
   assign gnt_vld = |gnt;
   assign preempt = preempt_q;

endmodule

// File: tb/tb_arb4_rr.sv
// Directed-vector bench for arb4_rr (MAX_HOLD = 8); expected grants are hand-derived per cycle.
module tb_arb4_rr;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       preempt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   arb4_rr #(.MAX_HOLD(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .preempt (preempt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply inputs on the falling edge, then sample just after the next rising edge.
   task automatic cyc(input logic [3:0] r, input logic rs);
      @(negedge clk);
      req = r;
      rst = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] one;
      one = 4'b0001;
      rst = 1'b1;
      req = 4'b0000;

      // Reset state
      cyc(4'b0000, 1'b1);
      check("rst_gnt", gnt, 4'b0000);
      check("rst_idx", gnt_idx, 2'd0);
      check("rst_vld", gnt_vld, 1'b0);
      check("rst_pre", preempt, 1'b0);
      cyc(4'b0000, 1'b0);
      check("idle_noreq", gnt, 4'b0000);

      // Single requester, one-cycle latency
      cyc(4'b0001, 1'b0);
      check("r27_gnt", gnt, 4'b0001);
      check("r27_idx", gnt_idx, 2'd0);
      check("r27_vld", gnt_vld, 1'b1);
      check("r27_pre", preempt, 1'b0);
      cyc(4'b0000, 1'b0);
      check("r27_release", gnt, 4'b0000);

      // Round-robin with back-to-back handover
      cyc(4'b0000, 1'b1);
      cyc(4'b1111, 1'b0);
      check("r28_first", gnt, 4'b0001);
      for (int k = 0; k < 4; k++) begin
         cyc(4'b1111, 1'b0);
         check($sformatf("r28_hold%0d", k), gnt, one << k);
         cyc(4'b1111 & ~(one << k), 1'b0);
         check($sformatf("r28_next%0d", k), gnt, one << ((k + 1) % 4));
         check($sformatf("r28_pre%0d", k), preempt, 1'b0);
      end
      cyc(4'b0000, 1'b0);
      check("r28_idle", gnt, 4'b0000);

      // Hold-limit preemption
      cyc(4'b0000, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         cyc((i >= 3) ? 4'b0101 : 4'b0001, 1'b0);
         check($sformatf("r29_own0_c%0d", i), gnt, 4'b0001);
         check($sformatf("r29_nopre_c%0d", i), preempt, 1'b0);
      end
      cyc(4'b0101, 1'b0);
      check("r29_pre_gnt", gnt, 4'b0100);
      check("r29_pre_idx", gnt_idx, 2'd2);
      check("r29_pre_pulse", preempt, 1'b1);
      cyc(4'b0101, 1'b0);
      check("r29_pre_once", preempt, 1'b0);
      check("r29_keep2", gnt, 4'b0100);
      cyc(4'b0000, 1'b0);
      check("r29_idle", gnt, 4'b0000);

      // Lone requester keeps grant indefinitely
      cyc(4'b0000, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         cyc(4'b0010, 1'b0);
         check($sformatf("r30_gnt_c%0d", i), gnt, 4'b0010);
         check($sformatf("r30_pre_c%0d", i), preempt, 1'b0);
      end
      cyc(4'b0000, 1'b0);

      // Release coincident with expiry counts as release
      cyc(4'b0000, 1'b1);
      cyc(4'b0010, 1'b0);
      check("r31_own1", gnt, 4'b0010);
      for (int i = 2; i <= 8; i++) begin
         cyc(4'b1010, 1'b0);
         check($sformatf("r31_keep_c%0d", i), gnt, 4'b0010);
      end
      cyc(4'b1000, 1'b0);
      check("r31_gnt3", gnt, 4'b1000);
      check("r31_idx3", gnt_idx, 2'd3);
      check("r31_nopre", preempt, 1'b0);
      cyc(4'b0000, 1'b0);

      // Reset during ownership drops grant and restores pointer
      cyc(4'b0000, 1'b1);
      cyc(4'b0100, 1'b0);
      check("r32_own2", gnt, 4'b0100);
      cyc(4'b0110, 1'b0);
      check("r32_keep2", gnt, 4'b0100);
      cyc(4'b0110, 1'b1);
      check("r32_rst_gnt", gnt, 4'b0000);
      check("r32_rst_vld", gnt_vld, 1'b0);
      cyc(4'b0110, 1'b1);
      check("r32_rst_ignore", gnt, 4'b0000);
      cyc(4'b0110, 1'b0);
      check("r32_after_gnt", gnt, 4'b0010);
      check("r32_after_idx", gnt_idx, 2'd1);
      cyc(4'b0000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/arb4_rr.md
ARB4_RR -- requirements
Module: arb4_rr

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles before forced rotation when other requests are pending; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  request per requester; bit i high = requester i wants the shared resource; held high for the whole usage.
REQ-005 gnt  output  4  one-hot grant; bit i high = requester i owns the resource; registered.
REQ-006 gnt_idx  output  2  binary index of current owner; valid only when gnt_vld high; registered.
REQ-007 gnt_vld  output  1  high when any grant is active; equals OR of gnt.
REQ-008 preempt  output  1  one-cycle pulse coincident with the first cycle of a grant that was forced by hold-limit expiry.

Function
REQ-009 gnt SHALL be the 2-to-4 decode of gnt_idx gated by gnt_vld; never more than one bit high.
REQ-010 States SHALL be IDLE (no owner) and OWN (owner = gnt_idx).
REQ-011 Priority pointer last[1:0] SHALL hold the most recently granted index; search order is last+1, last+2, last+3, last (mod 4).
REQ-012 IDLE: if req != 0, next cycle SHALL enter OWN with gnt_idx = first requester in search order; latency req-to-gnt = 1 cycle.
REQ-013 IDLE with req == 0: remain IDLE, gnt = 0.
REQ-014 OWN, owner's req low (release): if other req pending, next cycle grants next winner in search order (no dead cycle); else next cycle IDLE.
REQ-015 Hold counter hold_cnt (8 bits) SHALL load 0 on every new grant and increment each OWN cycle, saturating at MAX_HOLD-1.
REQ-016 OWN with owner's req high, hold_cnt == MAX_HOLD-1 and any other req high: next cycle grants next other winner, preempt pulses in that cycle.
REQ-017 OWN with owner's req high and no other req: owner retains grant indefinitely; hold_cnt stays saturated; no preempt.
REQ-018 Release and expiry in the same cycle SHALL be treated as release (preempt stays low).
REQ-019 last SHALL update to the new gnt_idx on every grant, including preemptive ones.
REQ-020 Requests arriving while OWN SHALL not alter the current grant except via REQ-014/REQ-016.

Reset
REQ-021 On clk edge with rst high: state IDLE, gnt 0, gnt_idx 0, gnt_vld 0, preempt 0, hold_cnt 0, last 3 (requester 0 first priority).
REQ-022 rst asserted during OWN SHALL drop gnt on that same edge; req is ignored while rst is high.
REQ-023 First grant possible on the edge after rst deasserts (1-cycle latency from REQ-012).

Structure
REQ-024 Shared package/include SHALL hold state encodings (IDLE=0, OWN=1), NUM_REQ=4 and the default MAX_HOLD.
REQ-025 One sub-module, grant_dec: combinational 2-to-4 decoder with enable producing gnt from gnt_idx and gnt_vld.
REQ-026 Winner selection SHALL be a combinational rotate-priority function of req and last, excluding the current owner for preemption.

Verification
REQ-027 Reset then req=0001 -> cycle 1 gnt=0001, gnt_idx=0, preempt=0.
REQ-028 req=1111 held; each owner drops req after 2 cycles then reasserts -> grant order 0,1,2,3,0 with no dead cycles.
REQ-029 MAX_HOLD=8, req0 held, req2 asserted at cycle 3 -> gnt=0001 for 8 cycles, then gnt=0100 with preempt=1 for exactly one cycle.
REQ-030 req=0010 held alone for 20 cycles -> gnt=0010 throughout, preempt never high.
REQ-031 Owner 1 releases in the same cycle its hold expires with req3 pending -> next gnt=1000, preempt=0.
REQ-032 rst pulsed mid-grant of requester 2 with req=0110 -> gnt=0000 on rst edge; after release gnt=0010 (pointer back to 3).
